// File: rtl/exwb_rob_arbiter_if.sv
// rtl/exwb_rob_arbiter_if.sv - EXWB-to-ROB writeback arbiter handshake bundle
interface exwb_rob_arbiter_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              flush;

    logic              alu_valid;
    logic              alu_ready;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;

    logic              fwd_valid;
    logic              fwd_ready;
    logic [TAG_W-1:0]  fwd_tag;
    logic [DATA_W-1:0] fwd_data;

    logic              jmp_valid;
    logic              jmp_ready;
    logic [TAG_W-1:0]  jmp_tag;
    logic [DATA_W-1:0] jmp_target;
    logic              jmp_taken;

    logic              wb_valid;
    logic              wb_ready;
    logic [1:0]        wb_src;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_taken;

    // Execution units and ROB side: drives results and wb_ready
    modport master (
        output flush,
        output alu_valid, alu_tag, alu_data, input alu_ready,
        output fwd_valid, fwd_tag, fwd_data, input fwd_ready,
        output jmp_valid, jmp_tag, jmp_target, jmp_taken, input jmp_ready,
        output wb_ready,
        input  wb_valid, wb_src, wb_tag, wb_data, wb_taken
    );

    // Arbiter side
    modport slave (
        input  flush,
        input  alu_valid, alu_tag, alu_data, output alu_ready,
        input  fwd_valid, fwd_tag, fwd_data, output fwd_ready,
        input  jmp_valid, jmp_tag, jmp_target, jmp_taken, output jmp_ready,
        input  wb_ready,
        output wb_valid, wb_src, wb_tag, wb_data, wb_taken
    );
endinterface

// File: rtl/exwb_rob_arbiter.sv
// rtl/exwb_rob_arbiter.sv - per-source FIFOs and jump-priority round-robin writeback arbiter
module exwb_rob_arbiter #(
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    exwb_rob_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    // Source index 0 = ALU, 1 = forwarder, 2 = jump; matches wb_src encoding
    logic [2:0]        in_valid;
    logic [2:0]        in_taken;
    logic [TAG_W-1:0]  in_tag  [3];
    logic [DATA_W-1:0] in_data [3];

    logic [TAG_W-1:0]  tag_mem_q   [3][DEPTH];
    logic [DATA_W-1:0] data_mem_q  [3][DEPTH];
    logic [DEPTH-1:0]  taken_mem_q [3];

    logic [CW-1:0] cnt_q    [3];
    logic [CW-1:0] cnt_d    [3];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];

    logic [2:0] has_head;
    logic [2:0] push;
    logic [2:0] win;
    logic [2:0] pop;
    logic       load;
    logic       af_any;

    logic [SW-1:0]     starve_q, starve_d;
    logic              rr_q, rr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [1:0]        wb_src_q, wb_src_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_taken_q, wb_taken_d;

    // Ready comes straight from the registered counts, never from wb_ready
    assign bus.alu_ready = (cnt_q[0] != FULL);
    assign bus.fwd_ready = (cnt_q[1] != FULL);
    assign bus.jmp_ready = (cnt_q[2] != FULL);

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_src   = wb_src_q;
    assign bus.wb_tag   = wb_tag_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_taken = wb_taken_q;

    // Gather the three source ports into indexable form
    always_comb begin
        in_valid   = {bus.jmp_valid, bus.fwd_valid, bus.alu_valid};
        in_taken   = {bus.jmp_taken, 1'b0, 1'b0};
        in_tag[0]  = bus.alu_tag;
        in_tag[1]  = bus.fwd_tag;
        in_tag[2]  = bus.jmp_tag;
        in_data[0] = bus.alu_data;
        in_data[1] = bus.fwd_data;
        in_data[2] = bus.jmp_target;
    end

    // Winner selection: jump first unless it has starved a waiting ALU/forwarder head
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            has_head[s] = (cnt_q[s] != '0);
            push[s]     = in_valid[s] && (cnt_q[s] != FULL);
        end
        load   = !wb_valid_q || bus.wb_ready;
        af_any = has_head[0] || has_head[1];
        win    = 3'b000;
        if (has_head[2] && ((starve_q < SMAX) || !af_any)) begin
            win[2] = 1'b1;
        end else if (has_head[0] && (!has_head[1] || !rr_q)) begin
            win[0] = 1'b1;
        end else if (has_head[1]) begin
            win[1] = 1'b1;
        end
        pop = load ? win : 3'b000;
    end

    // FIFO bookkeeping and output-register next state
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PW'(1) : wr_ptr_q[s];
            rd_ptr_d[s] = pop[s]  ? rd_ptr_q[s] + PW'(1) : rd_ptr_q[s];
        end
        wb_valid_d = wb_valid_q;
        wb_src_d   = wb_src_q;
        wb_tag_d   = wb_tag_q;
        wb_data_d  = wb_data_q;
        wb_taken_d = wb_taken_q;
        starve_d   = starve_q;
        rr_d       = rr_q;
        if (load) begin
            wb_valid_d = |win;
            for (int s = 0; s < 3; s++) begin
                if (win[s]) begin
                    wb_src_d   = 2'(s);
                    wb_tag_d   = tag_mem_q[s][rd_ptr_q[s]];
                    wb_data_d  = data_mem_q[s][rd_ptr_q[s]];
                    wb_taken_d = taken_mem_q[s][rd_ptr_q[s]];
                end
            end
            // Only a jump grant over a waiting ALU/forwarder head counts as starvation
            if (win[2] && af_any) begin
                starve_d = (starve_q == SMAX) ? SMAX : starve_q + SW'(1);
            end else begin
                starve_d = '0;
            end
            if (win[0]) begin
                rr_d = 1'b1;
            end else if (win[1]) begin
                rr_d = 1'b0;
            end
        end
    end

    // FIFO storage; stale slots are harmless because pointers and counts gate reads
    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                tag_mem_q[s][wr_ptr_q[s]]   <= in_tag[s];
                data_mem_q[s][wr_ptr_q[s]]  <= in_data[s];
                taken_mem_q[s][wr_ptr_q[s]] <= in_taken[s];
            end
        end
    end

    // Control state: reset clears everything, flush drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            starve_q   <= '0;
            rr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_src_q   <= 2'd0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            wb_taken_q <= 1'b0;
        end else if (bus.flush) begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            starve_q   <= '0;
            rr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s]    <= cnt_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
            starve_q   <= starve_d;
            rr_q       <= rr_d;
            wb_valid_q <= wb_valid_d;
            wb_src_q   <= wb_src_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            wb_taken_q <= wb_taken_d;
        end
    end
endmodule

// File: tb/tb_exwb_rob_arbiter.sv
// tb/tb_exwb_rob_arbiter.sv - directed self-checking bench for exwb_rob_arbiter
module tb_exwb_rob_arbiter;
    logic clk = 1'b0;
    logic rst;

    exwb_rob_arbiter_if #(.TAG_W(4), .DATA_W(32)) bus ();

    exwb_rob_arbiter #(
        .TAG_W(4), .DATA_W(32), .DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int          alu_q[$];
    int          fwd_q[$];
    int          jmp_q[$];
    logic [63:0] out_log[$];
    logic [63:0] exp_q[$];
    logic [63:0] wb_log[64];
    logic        rdy_log[64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dat(input int s, input int t);
        return 32'(((s + 1) << 16) | t);
    endfunction

    function automatic logic [63:0] ent(input int s, input int t);
        logic tk;
        tk = (s == 2) && ((t % 2) == 1);
        return {24'b0, 1'b1, tk, 2'(s), 4'(t), dat(s, t)};
    endfunction

    function automatic logic [63:0] snap();
        return {24'b0, bus.wb_valid, bus.wb_taken, bus.wb_src, bus.wb_tag, bus.wb_data};
    endfunction

    task automatic idle;
        bus.alu_valid = 1'b0;
        bus.fwd_valid = 1'b0;
        bus.jmp_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_flush;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    // Feed the source queues with a valid/ready handshake and log every wb handshake
    task automatic run(input int ncyc, input int stall);
        logic fa, ff, fj;
        out_log.delete();
        for (int c = 0; c < ncyc; c++) begin
            bus.alu_valid = (alu_q.size() > 0);
            if (alu_q.size() > 0) begin
                bus.alu_tag  = 4'(alu_q[0]);
                bus.alu_data = dat(0, alu_q[0]);
            end
            bus.fwd_valid = (fwd_q.size() > 0);
            if (fwd_q.size() > 0) begin
                bus.fwd_tag  = 4'(fwd_q[0]);
                bus.fwd_data = dat(1, fwd_q[0]);
            end
            bus.jmp_valid = (jmp_q.size() > 0);
            if (jmp_q.size() > 0) begin
                bus.jmp_tag    = 4'(jmp_q[0]);
                bus.jmp_target = dat(2, jmp_q[0]);
                bus.jmp_taken  = ((jmp_q[0] % 2) == 1);
            end
            bus.wb_ready = (c >= stall);
            rdy_log[c] = bus.alu_ready;
            wb_log[c]  = snap();
            if (bus.wb_valid && bus.wb_ready) out_log.push_back(snap());
            fa = bus.alu_valid && bus.alu_ready;
            ff = bus.fwd_valid && bus.fwd_ready;
            fj = bus.jmp_valid && bus.jmp_ready;
            tick();
            if (fa) void'(alu_q.pop_front());
            if (ff) void'(fwd_q.pop_front());
            if (fj) void'(jmp_q.pop_front());
        end
        idle();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(out_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i),
                  (i < out_log.size()) ? out_log[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.alu_tag = '0; bus.alu_data = '0;
        bus.fwd_tag = '0; bus.fwd_data = '0;
        bus.jmp_tag = '0; bus.jmp_target = '0; bus.jmp_taken = 1'b0;
        bus.wb_ready = 1'b1;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_src",   64'(bus.wb_src),   64'd0);
        check("rst_wb_tag",   64'(bus.wb_tag),   64'd0);
        check("rst_wb_data",  64'(bus.wb_data),  64'd0);
        check("rst_wb_taken", 64'(bus.wb_taken), 64'd0);
        check("rst_alu_rdy",  64'(bus.alu_ready), 64'd1);
        check("rst_fwd_rdy",  64'(bus.fwd_ready), 64'd1);
        check("rst_jmp_rdy",  64'(bus.jmp_ready), 64'd1);

        // Single ALU result: two-edge latency, then bubble
        bus.alu_valid = 1'b1;
        bus.alu_tag   = 4'd3;
        bus.alu_data  = 32'h1234;
        tick();
        bus.alu_valid = 1'b0;
        check("one_early_valid", 64'(bus.wb_valid), 64'd0);
        tick();
        check("one_valid", 64'(bus.wb_valid), 64'd1);
        check("one_src",   64'(bus.wb_src),   64'd0);
        check("one_tag",   64'(bus.wb_tag),   64'd3);
        check("one_data",  64'(bus.wb_data),  64'h1234);
        check("one_taken", 64'(bus.wb_taken), 64'd0);
        tick();
        check("one_drain_valid", 64'(bus.wb_valid), 64'd0);

        // Round-robin between ALU and forwarder
        do_flush();
        alu_q = '{1, 2, 3};
        fwd_q = '{1, 2, 3};
        run(14, 0);
        exp_q = '{ent(0,1), ent(1,1), ent(0,2), ent(1,2), ent(0,3), ent(1,3)};
        check_log("rr");

        // Jump priority with starvation guard
        do_flush();
        alu_q = '{5};
        jmp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run(24, 0);
        exp_q = '{ent(2,1), ent(2,2), ent(2,3), ent(2,4), ent(0,5),
                  ent(2,5), ent(2,6), ent(2,7), ent(2,8)};
        check_log("starve");

        // Backpressure: output held, ALU FIFO fills, nothing lost afterwards
        do_flush();
        alu_q = '{1, 2, 3, 4, 5};
        run(20, 5);
        check("bp_rdy_c1", 64'(rdy_log[1]), 64'd1);
        check("bp_rdy_c2", 64'(rdy_log[2]), 64'd1);
        check("bp_rdy_c3", 64'(rdy_log[3]), 64'd0);
        check("bp_rdy_c4", 64'(rdy_log[4]), 64'd0);
        check("bp_rdy_c5", 64'(rdy_log[5]), 64'd0);
        for (int c = 2; c <= 5; c++) check($sformatf("bp_hold_c%0d", c), wb_log[c], ent(0, 1));
        exp_q = '{ent(0,1), ent(0,2), ent(0,3), ent(0,4), ent(0,5)};
        check_log("bp");

        // Flush with full FIFOs and a held output
        do_flush();
        bus.wb_ready  = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_data   = dat(0, 1);
        bus.fwd_valid = 1'b1; bus.fwd_tag = 4'd1; bus.fwd_data   = dat(1, 1);
        bus.jmp_valid = 1'b1; bus.jmp_tag = 4'd1; bus.jmp_target = dat(2, 1); bus.jmp_taken = 1'b1;
        tick();
        bus.alu_tag = 4'd2; bus.alu_data = dat(0, 2);
        bus.fwd_tag = 4'd2; bus.fwd_data = dat(1, 2);
        bus.jmp_tag = 4'd2; bus.jmp_target = dat(2, 2); bus.jmp_taken = 1'b0;
        tick();
        bus.alu_valid = 1'b0;
        bus.fwd_valid = 1'b0;
        bus.jmp_tag = 4'd3; bus.jmp_target = dat(2, 3); bus.jmp_taken = 1'b1;
        tick();
        check("fl_held", snap(), ent(2, 1));
        check("fl_full_alu", 64'(bus.alu_ready), 64'd0);
        bus.flush     = 1'b1;
        bus.jmp_valid = 1'b1; bus.jmp_tag = 4'd9; bus.jmp_target = dat(2, 9); bus.jmp_taken = 1'b1;
        tick();
        idle();
        check("fl_wb_valid", 64'(bus.wb_valid),  64'd0);
        check("fl_alu_rdy",  64'(bus.alu_ready), 64'd1);
        check("fl_fwd_rdy",  64'(bus.fwd_ready), 64'd1);
        check("fl_jmp_rdy",  64'(bus.jmp_ready), 64'd1);
        run(8, 0);
        exp_q.delete();
        check_log("fl_empty");
        alu_q = '{7};
        run(5, 0);
        exp_q = '{ent(0,7)};
        check_log("fl_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
